// File: rtl/trigger_unit_if.sv
// Bus bundle between the trigger-source side and trigger_unit.
// The slave modport is the trigger unit; the master is the source/controller side.
interface trigger_unit_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic              Capture_En;
    logic              trigger_ready;
    logic [NUM_CH-1:0] trigger_vector;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] ch_edge;
    logic [NUM_CH-1:0] ch_pol;
    logic              combine_and;
    logic              arm;
    logic              auto_rearm;
    logic [CNT_W-1:0]  holdoff;
    logic              trigger_start;
    logic              armed;
    logic [CNT_W-1:0]  trig_count;

    modport master (
        output Capture_En, trigger_ready, trigger_vector, ch_mask, ch_edge, ch_pol,
               combine_and, arm, auto_rearm, holdoff,
        input  trigger_start, armed, trig_count
    );

    modport slave (
        input  Capture_En, trigger_ready, trigger_vector, ch_mask, ch_edge, ch_pol,
               combine_and, arm, auto_rearm, holdoff,
        output trigger_start, armed, trig_count
    );
endinterface

// File: rtl/trigger_unit.sv
// Multi-channel trigger qualifier with arm/fire/holdoff FSM and one-cycle start pulse.
// Optional fire counter enabled by defining TRIG_CNT_EN; otherwise trig_count is tied to 0.
module trigger_unit #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    trigger_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HOLDOFF} state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] contrib;
    logic              match;
    logic              fire;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic              start_q;
    logic              armed_q;

    // Masked channels are neutral for the chosen combine operator.
    always_comb begin
        hit     = '0;
        contrib = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.ch_edge[i])
                hit[i] = bus.ch_pol[i] ? (bus.trigger_vector[i] & ~prev_q[i])
                                       : (~bus.trigger_vector[i] & prev_q[i]);
            else
                hit[i] = bus.ch_pol[i] ? bus.trigger_vector[i] : ~bus.trigger_vector[i];
            contrib[i] = bus.ch_mask[i] ? hit[i] : bus.combine_and;
        end
        match = (|bus.ch_mask) & (bus.combine_and ? (&contrib) : (|contrib));
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        fire    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.Capture_En && bus.arm)
                    state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!bus.Capture_En) begin
                    state_d = S_IDLE;
                end else if (bus.trigger_ready && match) begin
                    state_d = S_HOLDOFF;
                    fire    = 1'b1;
                    hcnt_d  = bus.holdoff;
                end
            end
            S_HOLDOFF: begin
                if (!bus.Capture_En)
                    state_d = S_IDLE;
                else if (hcnt_q == '0)
                    state_d = bus.auto_rearm ? S_ARMED : S_IDLE;
                else
                    hcnt_d = hcnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            prev_q  <= '0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            prev_q  <= bus.trigger_vector;
            start_q <= fire;
            armed_q <= (state_d == S_ARMED);
        end
    end

    assign bus.trigger_start = start_q;
    assign bus.armed         = armed_q;

`ifdef TRIG_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts pulses since the last arm, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE && state_d == S_ARMED)
            cnt_d = '0;
        else if (start_q && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.trig_count = cnt_q;
`else
    assign bus.trig_count = '0;
`endif
endmodule
